// File: rtl/cpu_bus_cycle_if.sv
// cpu_bus_cycle_if: core, stack and external-bus signals of the MCS8 bus-cycle sequencer.
// Signal names keep their _I/_O suffix as seen from the sequencer.
//   slave  modport: the sequencer (cpu_bus_cycle)
//   master modport: whatever drives requests and the external bus (core, stack, pins)
// Core request : START_I, CYC_I[1:0], ASRC_I, HL_I[13:0], WDATA_I[7:0]
// Stack        : STK_DAT_I[7:0] in; STK_RD_O, STK_HA_O, STK_INCR_O out
// External bus : D_I[7:0], READY_I in; D_O[7:0], D_OE_O, STATE_O[2:0] out
// Core return  : RDATA_O[7:0], RVALID_O, DONE_O, BUSY_O
interface cpu_bus_cycle_if;
    logic        START_I;
    logic [1:0]  CYC_I;
    logic        ASRC_I;
    logic [13:0] HL_I;
    logic [7:0]  WDATA_I;
    logic [7:0]  STK_DAT_I;
    logic        STK_RD_O;
    logic        STK_HA_O;
    logic        STK_INCR_O;
    logic [7:0]  D_I;
    logic [7:0]  D_O;
    logic        D_OE_O;
    logic        READY_I;
    logic [2:0]  STATE_O;
    logic [7:0]  RDATA_O;
    logic        RVALID_O;
    logic        DONE_O;
    logic        BUSY_O;

    modport slave (
        input  START_I, CYC_I, ASRC_I, HL_I, WDATA_I, STK_DAT_I, D_I, READY_I,
        output STK_RD_O, STK_HA_O, STK_INCR_O, D_O, D_OE_O, STATE_O,
               RDATA_O, RVALID_O, DONE_O, BUSY_O
    );

    modport master (
        output START_I, CYC_I, ASRC_I, HL_I, WDATA_I, STK_DAT_I, D_I, READY_I,
        input  STK_RD_O, STK_HA_O, STK_INCR_O, D_O, D_OE_O, STATE_O,
               RDATA_O, RVALID_O, DONE_O, BUSY_O
    );
endinterface

// File: rtl/cpu_bus_cycle.sv
// cpu_bus_cycle: 8008-style bus-cycle sequencer (T1/T2/[WAIT]/T3) for the MCS8 core.
// Reads the 14-bit address (stack-top PC or HL) as low/high bytes, multiplexes it onto the
// external data bus, requests the post-fetch PC increment and returns read data.
// Ports:
//   CLK_I  : system clock, rising edge
//   nRST_I : asynchronous active-low reset
//   bus    : cpu_bus_cycle_if.slave (request, stack, external bus and return signals)
// Parameters:
//   IDLE_CODE : STATE_O code driven while idle (8008 STOPPED)
// Configuration:
//   CPU_BUS_WAIT_EN defined   : READY_I low at the T2 edge inserts WAIT states.
//   CPU_BUS_WAIT_EN undefined : READY_I ignored, no WAIT state is built.
module cpu_bus_cycle #(
    parameter logic [2:0] IDLE_CODE = 3'b110
) (
    input  logic           CLK_I,
    input  logic           nRST_I,
    cpu_bus_cycle_if.slave bus
);

`ifdef CPU_BUS_WAIT_EN
    typedef enum logic [2:0] {StIdle, StT1, StT2, StWait, StT3} state_e;
`else
    typedef enum logic [2:0] {StIdle, StT1, StT2, StT3} state_e;
`endif

    state_e      state_q, state_d;
    logic [1:0]  cyc_q, cyc_d;
    logic        asrc_q, asrc_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        latch;

    // Output decode
    logic [2:0]  state_code;
    logic        stk_rd, stk_ha, stk_incr;
    logic [7:0]  d_out;
    logic        d_oe;
    logic        done;

    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            state_q  <= StIdle;
            cyc_q    <= 2'b00;
            asrc_q   <= 1'b0;
            wdata_q  <= 8'h00;
            rdata_q  <= 8'h00;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            asrc_q   <= asrc_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        asrc_d   = asrc_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        latch    = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.START_I) begin
                    latch   = 1'b1;
                    state_d = StT1;
                end
            end
            StT1: state_d = StT2;
`ifdef CPU_BUS_WAIT_EN
            StT2: state_d = bus.READY_I ? StT3 : StWait;
            StWait: begin
                if (bus.READY_I) begin
                    state_d = StT3;
                end
            end
`else
            StT2: state_d = StT3;
`endif
            StT3: begin
                // Everything but a write (PCW) samples the bus, including I/O cycles.
                if (cyc_q != 2'b11) begin
                    rdata_d  = bus.D_I;
                    rvalid_d = 1'b1;
                end
                // A new request in T3 chains straight into T1 with no IDLE bubble.
                if (bus.START_I) begin
                    latch   = 1'b1;
                    state_d = StT1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (latch) begin
            cyc_d   = bus.CYC_I;
            asrc_d  = bus.ASRC_I;
            wdata_d = bus.WDATA_I;
        end
    end

    always_comb begin
        state_code = IDLE_CODE;
        stk_rd     = 1'b0;
        stk_ha     = 1'b0;
        stk_incr   = 1'b0;
        d_out      = 8'h00;
        d_oe       = 1'b0;
        done       = 1'b0;
        case (state_q)
            StT1: begin
                state_code = 3'b010;
                stk_rd     = ~asrc_q;
                d_out      = asrc_q ? bus.HL_I[7:0] : bus.STK_DAT_I;
                d_oe       = 1'b1;
            end
            StT2: begin
                state_code = 3'b001;
                stk_rd     = ~asrc_q;
                stk_ha     = 1'b1;
                // High address byte carries the cycle type in bits 7:6.
                d_out      = {cyc_q, asrc_q ? bus.HL_I[13:8] : bus.STK_DAT_I[5:0]};
                d_oe       = 1'b1;
                stk_incr   = (cyc_q == 2'b00) && !asrc_q;
            end
`ifdef CPU_BUS_WAIT_EN
            StWait: state_code = 3'b000;
`endif
            StT3: begin
                state_code = 3'b100;
                done       = 1'b1;
                if (cyc_q == 2'b11) begin
                    d_out = wdata_q;
                    d_oe  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.STATE_O    = state_code;
    assign bus.STK_RD_O   = stk_rd;
    assign bus.STK_HA_O   = stk_ha;
    assign bus.STK_INCR_O = stk_incr;
    assign bus.D_O        = d_out;
    assign bus.D_OE_O     = d_oe;
    assign bus.DONE_O     = done;
    assign bus.BUSY_O     = (state_q != StIdle);
    assign bus.RDATA_O    = rdata_q;
    assign bus.RVALID_O   = rvalid_q;

endmodule

// File: tb/tb_cpu_bus_cycle.sv
// tb_cpu_bus_cycle: randomized self-checking bench for cpu_bus_cycle.
// Transactions are drawn at random (plus a few fixed ones); the expected per-clock bus
// trace is derived from each transaction's fields, and the stack is a tiny PC model.
module tb_cpu_bus_cycle;
    localparam int NumTxn = 60;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cpu_bus_cycle_if bus ();

    cpu_bus_cycle dut (
        .CLK_I  (clk),
        .nRST_I (rst_n),
        .bus    (bus)
    );

    // Stack model: returns the PC byte selected by the high-byte strobe.
    logic [13:0] pc_cur;
    assign bus.STK_DAT_I = bus.STK_HA_O ? {2'b00, pc_cur[13:8]} : pc_cur[7:0];

    int n_vec = 0;
    int n_err = 0;

    logic       rv_arm;
    logic [7:0] rv_data;
    logic [7:0] exp_rdata;

    logic [1:0]  t_cyc  [NumTxn];
    logic        t_asrc [NumTxn];
    logic [13:0] t_hl   [NumTxn];
    logic [13:0] t_pc   [NumTxn];
    logic [7:0]  t_wd   [NumTxn];
    logic [7:0]  t_din  [NumTxn];
    int          t_wait [NumTxn];
    logic        t_b2b  [NumTxn];
    int          t_gap  [NumTxn];

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Check one clock's outputs mid-cycle, then advance to just after the next rising edge.
    task automatic tick(input logic [2:0] e_st, input logic e_oe, input logic [7:0] e_do,
                        input logic e_rd, input logic e_ha, input logic e_incr,
                        input logic e_done, input logic e_busy);
        logic e_rv;
        @(negedge clk);
        e_rv = rv_arm;
        if (rv_arm) exp_rdata = rv_data;
        rv_arm = 1'b0;
        check_eq("state",  16'(bus.STATE_O),    16'(e_st));
        check_eq("d_oe",   16'(bus.D_OE_O),     16'(e_oe));
        check_eq("d_o",    16'(bus.D_O),        16'(e_do));
        check_eq("stk_rd", 16'(bus.STK_RD_O),   16'(e_rd));
        check_eq("stk_ha", 16'(bus.STK_HA_O),   16'(e_ha));
        check_eq("incr",   16'(bus.STK_INCR_O), 16'(e_incr));
        check_eq("done",   16'(bus.DONE_O),     16'(e_done));
        check_eq("busy",   16'(bus.BUSY_O),     16'(e_busy));
        check_eq("rvalid", 16'(bus.RVALID_O),   16'(e_rv));
        check_eq("rdata",  16'(bus.RDATA_O),    16'(exp_rdata));
        @(posedge clk);
        #1;
    endtask

    task automatic tick_idle();
        tick(3'b110, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Junk on every latched or don't-care input; latched values must not follow it.
    task automatic scramble();
        bus.START_I = 1'($urandom);
        bus.CYC_I   = 2'($urandom);
        bus.ASRC_I  = 1'($urandom);
        bus.WDATA_I = 8'($urandom);
        bus.D_I     = 8'($urandom);
        bus.READY_I = 1'($urandom);
    endtask

    initial begin
        for (int i = 0; i < NumTxn; i++) begin
            t_cyc[i]  = 2'($urandom);
            t_asrc[i] = 1'($urandom);
            t_hl[i]   = 14'($urandom);
            t_pc[i]   = 14'($urandom);
            t_wd[i]   = 8'($urandom);
            t_din[i]  = 8'($urandom);
            t_b2b[i]  = 1'($urandom);
            t_gap[i]  = int'($urandom_range(0, 2));
`ifdef CPU_BUS_WAIT_EN
            t_wait[i] = int'($urandom_range(0, 3));
`else
            t_wait[i] = 0;
`endif
        end
        // PC fetch from 0x1234, read data 0x5A
        t_cyc[0] = 2'b00; t_asrc[0] = 1'b0; t_pc[0] = 14'h1234; t_din[0] = 8'h5A;
        t_b2b[0] = 1'b0;
        // HL write to 0x2ABC with 0xC3
        t_cyc[1] = 2'b11; t_asrc[1] = 1'b1; t_hl[1] = 14'h2ABC; t_wd[1] = 8'hC3;
        t_b2b[1] = 1'b0;
`ifdef CPU_BUS_WAIT_EN
        t_wait[2] = 3;
`endif
        t_b2b[2] = 1'b1;
        t_b2b[3] = 1'b1;
        t_b2b[NumTxn-1] = 1'b0;

        rst_n       = 1'b0;
        bus.START_I = 1'b0;
        bus.CYC_I   = 2'b00;
        bus.ASRC_I  = 1'b0;
        bus.HL_I    = 14'h0000;
        bus.WDATA_I = 8'h00;
        bus.D_I     = 8'h00;
        bus.READY_I = 1'b1;
        pc_cur      = 14'h0000;
        rv_arm      = 1'b0;
        rv_data     = 8'h00;
        exp_rdata   = 8'h00;

        #2;
        check_eq("rst_state",  16'(bus.STATE_O),    16'h0006);
        check_eq("rst_d_oe",   16'(bus.D_OE_O),     16'h0000);
        check_eq("rst_d_o",    16'(bus.D_O),        16'h0000);
        check_eq("rst_stk_rd", 16'(bus.STK_RD_O),   16'h0000);
        check_eq("rst_incr",   16'(bus.STK_INCR_O), 16'h0000);
        check_eq("rst_rdata",  16'(bus.RDATA_O),    16'h0000);
        check_eq("rst_rvalid", 16'(bus.RVALID_O),   16'h0000);
        check_eq("rst_done",   16'(bus.DONE_O),     16'h0000);
        check_eq("rst_busy",   16'(bus.BUSY_O),     16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NumTxn; i++) begin
            if (i == 0 || !t_b2b[i-1]) begin
                for (int g = 0; g < t_gap[i]; g++) begin
                    scramble();
                    bus.START_I = 1'b0;
                    tick_idle();
                end
                scramble();
                bus.START_I = 1'b1;
                bus.CYC_I   = t_cyc[i];
                bus.ASRC_I  = t_asrc[i];
                bus.WDATA_I = t_wd[i];
                tick_idle();
            end
            // T1: low address byte
            scramble();
            bus.HL_I = t_hl[i];
            pc_cur   = t_pc[i];
            tick(3'b010, 1'b1, t_asrc[i] ? t_hl[i][7:0] : t_pc[i][7:0],
                 !t_asrc[i], 1'b0, 1'b0, 1'b0, 1'b1);
            // T2: cycle type + high address byte
            scramble();
`ifdef CPU_BUS_WAIT_EN
            bus.READY_I = (t_wait[i] == 0);
`endif
            tick(3'b001, 1'b1, {t_cyc[i], t_asrc[i] ? t_hl[i][13:8] : t_pc[i][13:8]},
                 !t_asrc[i], 1'b1, (t_cyc[i] == 2'b00) && !t_asrc[i], 1'b0, 1'b1);
            for (int w = 0; w < t_wait[i]; w++) begin
                scramble();
                bus.READY_I = (w == t_wait[i] - 1);
                tick(3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            end
            // T3: write data out or read data sampled
            scramble();
            bus.D_I     = t_din[i];
            bus.START_I = t_b2b[i];
            if (t_b2b[i]) begin
                bus.CYC_I   = t_cyc[i+1];
                bus.ASRC_I  = t_asrc[i+1];
                bus.WDATA_I = t_wd[i+1];
            end
            tick(3'b100, t_cyc[i] == 2'b11, (t_cyc[i] == 2'b11) ? t_wd[i] : 8'h00,
                 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            if (t_cyc[i] != 2'b11) begin
                rv_arm  = 1'b1;
                rv_data = t_din[i];
            end
        end

        scramble();
        bus.START_I = 1'b0;
        tick_idle();
        tick_idle();

        // Reset while a fetch sits in T2.
        scramble();
        bus.START_I = 1'b1;
        bus.CYC_I   = 2'b00;
        bus.ASRC_I  = 1'b0;
        tick_idle();
        scramble();
        bus.START_I = 1'b0;
        pc_cur      = 14'h0555;
        tick(3'b010, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_state",  16'(bus.STATE_O),    16'h0006);
        check_eq("abort_d_oe",   16'(bus.D_OE_O),     16'h0000);
        check_eq("abort_d_o",    16'(bus.D_O),        16'h0000);
        check_eq("abort_incr",   16'(bus.STK_INCR_O), 16'h0000);
        check_eq("abort_done",   16'(bus.DONE_O),     16'h0000);
        check_eq("abort_busy",   16'(bus.BUSY_O),     16'h0000);
        check_eq("abort_rvalid", 16'(bus.RVALID_O),   16'h0000);
        check_eq("abort_rdata",  16'(bus.RDATA_O),    16'h0000);
        exp_rdata = 8'h00;
        rv_arm    = 1'b0;
        @(negedge clk);
        rst_n       = 1'b1;
        bus.START_I = 1'b0;
        @(posedge clk);
        #1;
        tick_idle();
        tick_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
